// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and counter sizing for the PISO shift engine
package piso_pkg;
  typedef enum logic {PISO_IDLE, PISO_SHIFT} piso_state_e;
  function automatic int piso_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: up-counter with sync clear, enable and terminal-count flag
module piso_bit_counter #(
  parameter int WIDTH = 4,
  parameter int TERM  = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  assign tc_o = cnt_q == WIDTH'(TERM);
endmodule

// File: rtl/piso_shift_engine.sv
// piso_shift_engine: parameterised PISO shift engine; PISO_SERIAL_IN_EN adds serial_in/parallel_out
module piso_shift_engine
  import piso_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int SHIFT_COUNT = 2 * WORD_LENGTH,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] data_in,
  input  logic                   load,
  input  logic                   shift,
`ifdef PISO_SERIAL_IN_EN
  input  logic                   serial_in,
  output logic [SHIFT_COUNT-1:0] parallel_out,
`endif
  output logic                   data_out,
  output logic                   valid_out,
  output logic                   busy,
  output logic                   done
);
  localparam int CW = piso_cnt_width(SHIFT_COUNT);
  piso_state_e            state_q, state_d;
  logic [SHIFT_COUNT-1:0] sreg_q, sreg_d, shifted;
  logic                   done_q, done_d;
  logic                   fill, shift_acc, tc, last;
`ifdef PISO_SERIAL_IN_EN
  // the captured word stays visible after the final shift
  localparam bit KEEP_ON_DONE = 1'b1;
  assign fill         = serial_in;
  assign parallel_out = sreg_q;
`else
  localparam bit KEEP_ON_DONE = 1'b0;
  assign fill = 1'b0;
`endif
  assign shift_acc = (state_q == PISO_SHIFT) && shift && !load;
  assign last      = shift_acc && tc;
  assign shifted   = MSB_FIRST ? {sreg_q[SHIFT_COUNT-2:0], fill} : {fill, sreg_q[SHIFT_COUNT-1:1]};
  piso_bit_counter #(.WIDTH(CW), .TERM(SHIFT_COUNT - 1)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (load || last),
    .en_i  (shift_acc),
    .tc_o  (tc)
  );
  always_comb begin
    state_d = load ? PISO_SHIFT : last ? PISO_IDLE : state_q;
    sreg_d  = load ? SHIFT_COUNT'(data_in) : last ? (KEEP_ON_DONE ? shifted : '0) : shift_acc ? shifted : sreg_q;
    done_d  = last;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= PISO_IDLE;
      sreg_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      done_q  <= done_d;
    end
  assign busy      = state_q == PISO_SHIFT;
  assign valid_out = busy;
  assign done      = done_q;
  assign data_out  = busy && (MSB_FIRST ? sreg_q[SHIFT_COUNT-1] : sreg_q[0]);
endmodule

// File: tb/tb_piso_shift_engine.sv
// tb_piso_shift_engine: directed checks of LSB- and MSB-first engines sharing one stimulus
module tb_piso_shift_engine;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data_in = '0;
  logic       load = 1'b0;
  logic       shift = 1'b0;
  logic       serial_in = 1'b0;
  logic [7:0] po_l, po_m;
  logic       dl, vl, bl, ol, dm, vm, bm, om;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  piso_shift_engine #(.WORD_LENGTH(4), .SHIFT_COUNT(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .shift(shift),
`ifdef PISO_SERIAL_IN_EN
    .serial_in(serial_in), .parallel_out(po_l),
`endif
    .data_out(dl), .valid_out(vl), .busy(bl), .done(ol)
  );
  piso_shift_engine #(.WORD_LENGTH(4), .SHIFT_COUNT(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .shift(shift),
`ifdef PISO_SERIAL_IN_EN
    .serial_in(serial_in), .parallel_out(po_m),
`endif
    .data_out(dm), .valid_out(vm), .busy(bm), .done(om)
  );
`ifndef PISO_SERIAL_IN_EN
  assign po_l = '0;
  assign po_m = '0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outs(input string tag);
    check({tag, " data_l"}, dl, 0);
    check({tag, " data_m"}, dm, 0);
    check({tag, " valid_l"}, vl, 0);
    check({tag, " busy_m"}, bm, 0);
  endtask

  // ls/ms hold the expected emission order: bit i is the i-th bit on data_out
  task automatic run_word(input logic [3:0] d, input logic [7:0] ls, input logic [7:0] ms, input int gap);
    load = 1'b1; data_in = d; shift = 1'b0;
    tick;
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("busy_l", bl, 1);
      check("valid_m", vm, 1);
      check("done_l mid", ol, 0);
      check("bit_l", dl, ls[i]);
      check("bit_m", dm, ms[i]);
      for (int g = 0; g < gap; g++) begin
        tick;
        check("hold_l", dl, ls[i]);
        check("hold_m", dm, ms[i]);
      end
      shift = 1'b1;
      tick;
      shift = 1'b0;
    end
    check("done_l end", ol, 1);
    check("done_m end", om, 1);
    check("busy_l end", bl, 0);
    check("data_l end", dl, 0);
  endtask

  initial begin
    #2;
    idle_outs("reset");
    check("done reset", ol, 0);
    check("po reset", po_l, 0);
    tick;
    reset = 1'b0;
    shift = 1'b1;
    tick;
    shift = 1'b0;
    idle_outs("shift idle");

    run_word(4'b1011, 8'b0000_1011, 8'b1101_0000, 0);
    tick;
    check("done_l drop", ol, 0);
    check("done_m drop", om, 0);

    run_word(4'b1011, 8'b0000_1011, 8'b1101_0000, 2);
    // back-to-back: this load lands in the cycle done is high
    run_word(4'b0110, 8'b0000_0110, 8'b0110_0000, 0);
    tick;

    load = 1'b1; data_in = 4'b1011;
    tick;
    load = 1'b0;
    shift = 1'b1;
    repeat (3) begin
      tick;
      check("abort no done", ol, 0);
    end
    shift = 1'b0;
    run_word(4'b0110, 8'b0000_0110, 8'b0110_0000, 0);
    tick;

    load = 1'b1; data_in = 4'b1011;
    tick;
    shift = 1'b1;
    load = 1'b0;
    repeat (2) tick;
    load = 1'b1; data_in = 4'b1110;
    tick;
    load = 1'b0;
    check("ld+sh bit_l", dl, 0);
    check("ld+sh bit_m", dm, 0);
    check("ld+sh busy", bl, 1);
    repeat (4) tick;
    shift = 1'b0;
    check("5th bit_l", dl, 0);
    check("5th bit_m", dm, 1);
    #2 reset = 1'b1;
    #1;
    idle_outs("async reset");
    check("async done", ol, 0);
    tick;
    check("reset done", om, 0);
    reset = 1'b0;
    tick;
    idle_outs("after reset");
    check("after reset done", ol, 0);

`ifdef PISO_SERIAL_IN_EN
    load = 1'b1; data_in = 4'b0000;
    tick;
    load = 1'b0;
    serial_in = 1'b1;
    shift = 1'b1;
    repeat (8) tick;
    shift = 1'b0;
    serial_in = 1'b0;
    check("serial done", ol, 1);
    check("po_l full", po_l, 8'hFF);
    check("po_m full", po_m, 8'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
